fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 130 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pulls words out of a FIFO (one-cycle read latency) and presents them as a
// valid/ready stream. Words are buffered in a two-entry skid buffer. m_last_o marks every
// PKT_LEN-th word, and word_cnt_o counts transferred words.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_en_o  FIFO read request (never asserted while fifo_empty_i=1)
//   fifo_rdata_i  FIFO read data, valid the cycle after an accepted read
//   m_valid_o     stream valid (registered, no path from m_ready_i)
//   m_ready_i     stream ready
//   m_data_o      stream data (oldest buffered word)
//   m_last_o      last word of a PKT_LEN-word packet
//   word_cnt_o    wrapping count of completed handshakes
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [15:0]           word_cnt_o
);

  localparam int unsigned     PosW    = $clog2(PKT_LEN);
  localparam logic [PosW-1:0] PosLast = PosW'(PKT_LEN - 1);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  inflight_q;
  logic [PosW-1:0]       pos_q, pos_d;
  logic [15:0]           cnt_q;

  logic       hs;
  logic       capture;
  logic [1:0] occ;

  assign m_valid_o  = (state_q != StEmpty);
  assign m_data_o   = head_q;
  assign m_last_o   = m_valid_o && (pos_q == PosLast);
  assign word_cnt_o = cnt_q;

  assign hs      = m_valid_o & m_ready_i;
  assign capture = inflight_q;

  always_comb begin
    occ = 2'd0;
    case (state_q)
      StOne:   occ = 2'd1;
      StTwo:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  // A word leaving this cycle frees a slot, so it is credited before the limit check; this is
  // what lets a continuously-ready sink take one word per cycle. Buffer can never overflow
  // because occupancy + in-flight - handshake stays at or below one whenever a read issues.
  assign fifo_rd_en_o = !rst && !fifo_empty_i &&
                        (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, hs}));

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      StEmpty: begin
        if (capture) begin
          head_d  = fifo_rdata_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (capture && hs) begin
          head_d = fifo_rdata_i;
        end else if (capture) begin
          tail_d  = fifo_rdata_i;
          state_d = StTwo;
        end else if (hs) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // A capture cannot coincide with TWO: issue is throttled one cycle earlier.
        if (hs) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    pos_d = pos_q;
    if (hs) begin
      pos_d = (pos_q == PosLast) ? '0 : pos_q + PosW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;  // drops any read issued before reset
      pos_q      <= '0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= fifo_rd_en_o;
      pos_q      <= pos_d;
      if (hs) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  localparam int DW      = 8;
  localparam int PKT_LEN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty_i = 1'b1;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_rdata_i = '0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic [15:0]   word_cnt_o;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_rdata_i (fifo_rdata_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents not yet read, and the words the stream must deliver, in order.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] hs_words[$];
  logic [DW-1:0] last_words[$];

  int   hs_total  = 0;
  int   rd_en_cnt = 0;
  int   valid_cnt = 0;
  logic rd_en_s   = 1'b0;
  logic rst_prev  = 1'b0;
  logic hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Per-cycle compare against the stream model: output order equals FIFO load order, last on
  // every PKT_LEN-th handshake since reset, counter equals handshakes mod 2^16.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        chk("rst_valid", 32'(m_valid_o), 0);
        chk("rst_data", 32'(m_data_o), 0);
        chk("rst_last", 32'(m_last_o), 0);
        chk("rst_word_cnt", 32'(word_cnt_o), 0);
        hs_total = 0;
      end
      if (rst) begin
        chk("rd_en_in_rst", 32'(fifo_rd_en_o), 0);
        rd_en_s   = 1'b0;
        hold_prev = 1'b0;
      end else begin
        chk("word_cnt", 32'(word_cnt_o), 32'(hs_total[15:0]));
        chk("rd_en_while_empty", 32'(fifo_rd_en_o & fifo_empty_i), 0);
        chk("last", 32'(m_last_o),
            32'(m_valid_o && ((hs_total % PKT_LEN) == PKT_LEN - 1)));
        if (hold_prev) begin
          chk("hold_valid", 32'(m_valid_o), 1);
          chk("hold_data", 32'(m_data_o), 32'(prev_data));
          chk("hold_last", 32'(m_last_o), 32'(prev_last));
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 1);
          else chk("data", 32'(m_data_o), 32'(exp_q.pop_front()));
          hs_words.push_back(m_data_o);
          if (m_last_o) last_words.push_back(m_data_o);
          hs_total++;
        end
        hold_prev = m_valid_o && !m_ready_i;
        prev_data = m_data_o;
        prev_last = m_last_o;
        if (fifo_rd_en_o) rd_en_cnt++;
        if (m_valid_o) valid_cnt++;
        rd_en_s = fifo_rd_en_o;
      end
      rst_prev = rst;
    end
  end

  // One clock; the FIFO model answers a read sampled in the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_en_s) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fifo_underflow actual=read required=no_read");
      end else begin
        fifo_rdata_i = fifo_q.pop_front();
      end
    end
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    exp_q.delete();
    fifo_empty_i = 1'b1;
  endtask

  task automatic clear_logs();
    hs_words.delete();
    last_words.delete();
    rd_en_cnt = 0;
    valid_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_fifo();
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input int max_cyc, input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid_o) && n < max_cyc) begin
      if (rnd) m_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (exp_q.size() != 0 || m_valid_o) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_left required=0_left", exp_q.size());
    end
    m_ready_i = 1'b1;
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();

    // 16 words, always ready; first-valid latency and idle read enable afterwards.
    m_ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) load(8'(i));
    @(negedge clk);
    chk("lat_c0_rd_en", 32'(fifo_rd_en_o), 1);
    chk("lat_c0_valid", 32'(m_valid_o), 0);
    tick();
    @(negedge clk);
    chk("lat_c1_valid", 32'(m_valid_o), 0);
    tick();
    @(negedge clk);
    chk("lat_c2_valid", 32'(m_valid_o), 1);
    chk("lat_c2_data", 32'(m_data_o), 1);
    tick();
    drain(100, 1'b0);
    chk("s1_count", 32'(hs_words.size()), 16);
    for (int i = 0; i < 16 && i < hs_words.size(); i++) chk("s1_order", 32'(hs_words[i]), i + 1);
    chk("s1_last_count", 32'(last_words.size()), 1);
    if (last_words.size() > 0) chk("s1_last_word", 32'(last_words[0]), 16);
    chk("s1_word_cnt", 32'(word_cnt_o), 16);
    @(negedge clk);
    chk("s1_rd_en_idle", 32'(fifo_rd_en_o), 0);
    tick();

    // Back-pressure: 4 words, not ready for 10 cycles.
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) load(8'(i));
    repeat (10) tick();
    chk("s2_reads", 32'(rd_en_cnt), 2);
    chk("s2_valid", 32'(m_valid_o), 1);
    chk("s2_data", 32'(m_data_o), 1);
    m_ready_i = 1'b1;
    drain(100, 1'b0);
    chk("s2_count", 32'(hs_words.size()), 4);
    for (int i = 0; i < 4 && i < hs_words.size(); i++) chk("s2_order", 32'(hs_words[i]), i + 1);

    // Random ready over 40 words, FIFO refilled part way through.
    do_reset();
    for (int i = 1; i <= 25; i++) load(8'(i));
    repeat (30) begin
      m_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 26; i <= 40; i++) load(8'(i));
    drain(1000, 1'b1);
    chk("s3_count", 32'(hs_words.size()), 40);
    chk("s3_last_count", 32'(last_words.size()), 2);
    if (last_words.size() == 2) begin
      chk("s3_last_a", 32'(last_words[0]), 16);
      chk("s3_last_b", 32'(last_words[1]), 32);
    end
    chk("s3_word_cnt", 32'(word_cnt_o), 40);

    // FIFO empty for 20 cycles.
    do_reset();
    m_ready_i = 1'b1;
    repeat (20) tick();
    chk("s4_rd_en_cycles", 32'(rd_en_cnt), 0);
    chk("s4_valid_cycles", 32'(valid_cnt), 0);

    // Reset with a word buffered and a read in flight.
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) load(8'(i));
    tick();
    tick();
    chk("s5_pre_valid", 32'(m_valid_o), 1);
    rst = 1'b1;
    clear_fifo();
    tick();
    @(negedge clk);
    chk("s5_rst_valid", 32'(m_valid_o), 0);
    chk("s5_rst_data", 32'(m_data_o), 0);
    chk("s5_rst_rd_en", 32'(fifo_rd_en_o), 0);
    tick();
    rst = 1'b0;
    clear_logs();
    load(8'd7);
    load(8'd8);
    m_ready_i = 1'b1;
    drain(50, 1'b0);
    chk("s5_count", 32'(hs_words.size()), 2);
    if (hs_words.size() == 2) begin
      chk("s5_word_a", 32'(hs_words[0]), 7);
      chk("s5_word_b", 32'(hs_words[1]), 8);
    end
    chk("s5_word_cnt", 32'(word_cnt_o), 2);

    // Counter wrap: 65537 handshakes.
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 65537; i++) load(8'(i));
    drain(70000, 1'b0);
    chk("s6_count", 32'(hs_words.size()), 65537);
    chk("s6_word_cnt", 32'(word_cnt_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
